// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the MIPS32 fetch port and the load/store port.
// Optional MEM_ARB_FAIR_EN bounds how many data grants may overtake a waiting fetch.
module mem_port_arbiter #(
    parameter int WAIT_CYC   = 1,
    parameter int STREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       we_q;
    logic       fetch_turn;
    logic       grant_dm;
    logic       grant_if;

    if (WAIT_CYC < 0 || WAIT_CYC > 15 || STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_illegal_params
    end

`ifdef MEM_ARB_FAIR_EN
    // Counts data grants that overtook a waiting fetch; at the limit fetch takes the next slot.
    logic [3:0] streak;

    assign fetch_turn = if_req && (streak == 4'(STREAK_MAX));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (grant_if)
                streak <= '0;
            else if (grant_dm)
                streak <= if_req ? streak + 4'd1 : '0;
        end
    end
`else
    assign fetch_turn = 1'b0;
`endif

    assign grant_dm = dm_req && !fetch_turn;
    assign grant_if = if_req && !grant_dm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through this block can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_dm || grant_if) state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0)     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        busy   = 1'b0;
        if_ack = 1'b0;
        dm_ack = 1'b0;
        case (state)
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = owner && we_q;
                busy   = 1'b1;
            end
            RESP: begin
                busy   = 1'b1;
                if_ack = !owner;
                dm_ack = owner;
            end
            default: ;
        endcase
    end

    // Operands are frozen at grant, so requester changes during ACCESS are invisible to memory.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            we_q      <= 1'b0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                        we_q      <= dm_we;
                        owner     <= 1'b1;
                        wait_cnt  <= 4'(WAIT_CYC);
                    end else if (grant_if) begin
                        mem_addr  <= if_addr;
                        mem_be    <= 4'hF;
                        we_q      <= 1'b0;
                        owner     <= 1'b0;
                        wait_cnt  <= 4'(WAIT_CYC);
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (owner) begin
                        if (!we_q) dm_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized rounds scored against a transaction-level memory model.
module tb_mem_port_arbiter;

    localparam int W    = 1;
    localparam int SMAX = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ack, dm_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        owner, busy;

    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] model_if_rd, model_dm_rd;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.WAIT_CYC(W), .STREAK_MAX(SMAX)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = tb_mem[mem_addr[9:2]];

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          preload;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; the memory model commits any write that was presented during the cycle.
    task automatic tick();
        logic        wr;
        logic [7:0]  idx;
        logic [31:0] d;
        logic [3:0]  be;
        wr  = mem_en && mem_we;
        idx = mem_addr[9:2];
        d   = mem_wdata;
        be  = mem_be;
        @(posedge CLK);
        #1;
        if (wr) tb_mem[idx] = merge(tb_mem[idx], d, be);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int t   = 0;
        int en  = 0;
        bit got = 1'b0;
        if (v.preload) tb_mem[v.addr[9:2]] = v.pre_val;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        while (!got && t < 40) begin
            tick();
            t++;
            if (mem_en) begin
                en++;
                check($sformatf("v%0d mem_addr", k), mem_addr, v.addr);
                check($sformatf("v%0d mem_be", k), 32'(mem_be), v.is_dm ? 32'(v.be) : 32'hF);
                check($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(v.is_dm && v.we));
                check($sformatf("v%0d owner", k), 32'(owner), 32'(v.is_dm));
            end
            if (if_ack || dm_ack) got = 1'b1;
        end
        check($sformatf("v%0d acked", k), 32'(got), 32'd1);
        check($sformatf("v%0d ack latency", k), t, W + 2);
        check($sformatf("v%0d mem_en cycles", k), en, W + 1);
        check($sformatf("v%0d dm_ack", k), 32'(dm_ack), 32'(v.is_dm));
        check($sformatf("v%0d if_ack", k), 32'(if_ack), 32'(!v.is_dm));
        check($sformatf("v%0d mem_en in resp", k), 32'(mem_en), 32'd0);
        check($sformatf("v%0d mem_we in resp", k), 32'(mem_we), 32'd0);
        check($sformatf("v%0d rdata", k), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        check($sformatf("v%0d busy after", k), 32'(busy), 32'd0);
    endtask

    // Transaction-level round: data goes first when both ask, each takes WAIT_CYC+3 cycles.
    task automatic run_round(input bit do_if, input bit do_dm, input logic [31:0] ia,
                             input logic [31:0] da, input logic [31:0] wd,
                             input logic [3:0] be, input bit we, input string tag);
        int t = 0, if_t = 0, dm_t = 0, exp_if_t, exp_dm_t;
        if (do_dm) begin
            if (we) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], wd, be);
            else    model_dm_rd = ref_mem[da[9:2]];
        end
        if (do_if) model_if_rd = ref_mem[ia[9:2]];
        exp_dm_t = do_dm ? W + 2 : 0;
        exp_if_t = do_if ? W + 2 + (do_dm ? W + 3 : 0) : 0;

        if_req = do_if; if_addr = ia;
        dm_req = do_dm; dm_addr = da; dm_wdata = wd; dm_be = be; dm_we = we;
        while (((do_dm && dm_t == 0) || (do_if && if_t == 0)) && t < 80) begin
            tick();
            t++;
            if (t == 1) check({tag, " first owner"}, 32'(owner), 32'(do_dm));
            if (if_ack && dm_ack) check({tag, " ack overlap"}, 32'd1, 32'd0);
            if (dm_ack) begin dm_t = t; dm_req = 1'b0; end
            if (if_ack) begin if_t = t; if_req = 1'b0; end
        end
        check({tag, " dm_ack time"}, dm_t, exp_dm_t);
        check({tag, " if_ack time"}, if_t, exp_if_t);
        check({tag, " dm_rdata"}, dm_rdata, model_dm_rd);
        check({tag, " if_rdata"}, if_rdata, model_if_rd);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        int          seq [$];
        int          exp_owner, streak_m, n_acc, t;
        bit          if_pending, got;
        logic [1:0]  r;
        logic [31:0] v;

        vecs[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,          4'h0, 1'b1, 32'h1880_FFFE, 32'h1880_FFFE};
        vecs[1] = '{1'b1, 1'b1, 32'h1001_0000, 32'h0000_00AA, 4'h1, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0,          4'h0, 1'b0, 32'h0,          32'h0000_00AA};
        vecs[3] = '{1'b1, 1'b1, 32'h1001_0004, 32'h1122_3344, 4'hA, 1'b1, 32'hAABB_CCDD, 32'h0000_00AA};
        vecs[4] = '{1'b1, 1'b0, 32'h1001_0004, 32'h0,          4'h0, 1'b0, 32'h0,          32'h11BB_33DD};
        vecs[5] = '{1'b0, 1'b0, 32'h0040_0008, 32'h0,          4'h0, 1'b1, 32'h2402_0001, 32'h2402_0001};

        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;

        // Reset, then idle with no requests.
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst if_ack", 32'(if_ack), 32'd0);
        check("rst dm_ack", 32'(dm_ack), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst dm_rdata", dm_rdata, 32'd0);
        check("rst owner", 32'(owner), 32'd0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Data held high with fetch waiting.
        n_acc = FAIR ? 6 : 20;
        tb_mem[8] = 32'h8C82_0000;
        if_req = 1'b1; if_addr = 32'h0040_0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010;
        t = 0;
        while (seq.size() < n_acc && t < 400) begin
            tick();
            t++;
            if (dm_ack) begin
                seq.push_back(1);
                dm_addr = dm_addr ^ 32'h4;
            end
            if (if_ack) begin
                seq.push_back(0);
                if_req = 1'b0;
            end
        end
        check("fair ack count", seq.size(), n_acc);
        if_pending = 1'b1;
        streak_m   = 0;
        for (int k = 0; k < n_acc; k++) begin
            if (if_pending && FAIR && streak_m == SMAX) begin
                exp_owner  = 0;
                if_pending = 1'b0;
                streak_m   = 0;
            end else begin
                exp_owner = 1;
                streak_m  = if_pending ? streak_m + 1 : 0;
            end
            check($sformatf("fair ack %0d owner", k), k < seq.size() ? seq[k] : -1, exp_owner);
        end
        dm_req = 1'b0;
        got = 1'b0;
        t = 0;
        if (if_req) begin
            while (!got && t < 40) begin
                tick();
                t++;
                got = if_ack;
            end
            check("starved fetch drains", 32'(got), 32'd1);
            check("starved fetch rdata", if_rdata, 32'h8C82_0000);
        end
        if_req = 1'b0;
        repeat (6) tick();

        // Reset in the second ACCESS cycle of a load.
        tb_mem[3] = 32'h1234_5678;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_000C;
        tick();
        check("mid rst access1 mem_en", 32'(mem_en), 32'd1);
        tick();
        check("mid rst access2 mem_en", 32'(mem_en), 32'd1);
        reset = 1'b0;
        #1;
        check("mid rst mem_en", 32'(mem_en), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst dm_rdata", dm_rdata, 32'd0);
        dm_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid rst dm_ack", 32'(dm_ack), 32'd0);
        end
        reset = 1'b1;
        tick();
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst dm_ack", 32'(dm_ack), 32'd0);
        check("post rst dm_rdata", dm_rdata, 32'd0);

        // Randomized rounds against the reference memory; registers are zero after reset.
        model_if_rd = 32'h0;
        model_dm_rd = 32'h0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        run_round(1'b1, 1'b1, 32'h0040_0004, 32'h1001_0008, 32'h0, 4'h0, 1'b0, "contention");
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            run_round(r[0], r[1],
                      32'h0040_0000 | (32'($urandom_range(0, 15)) << 2),
                      32'h1001_0000 | (32'($urandom_range(0, 15)) << 2),
                      $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the MIPS32 instruction-fetch path and the load/store data path.
- Serialises requests, inserts a fixed memory wait count, returns read data and one-cycle acks to each requester.
- Sits between the core's IF/MEM stages and the unified memory of the SoC.

Parameters:
- WAIT_CYC, 1, extra memory wait cycles before rdata is valid; legal range 0..15.
- STREAK_MAX, 4, max consecutive data grants while fetch waits; used only with MEM_ARB_FAIR_EN; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch word address.
- if_rdata  out  32  fetched word, registered.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_be  in  4  store byte enables.
- dm_rdata  out  32  load data, registered.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; 4'b1111 for fetch.
- mem_rdata  in  32  memory read data.
- owner  out  1  0 = fetch, 1 = data; valid while busy.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, if_rdata and dm_rdata cleared to 0, wait counter 0, streak counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - At a clock edge with any req high, grant one requester.
  - Latch addr, we, wdata, be into the mem_* registers.
  - Set owner, load wait counter with WAIT_CYC, go to ACCESS.
  - If no req is high, stay in IDLE.
- Priority: dm_req wins over if_req (the older instruction goes first).
- ACCESS:
  - mem_en=1. mem_we equals the latched dm_we when owner=1, else 0.
  - mem_* are stable for the whole state.
  - At each edge with counter != 0, decrement the counter.
  - At the edge with counter == 0:
    - If the access is a read, capture mem_rdata into the owner's rdata register.
    - Set the owner's ack to 1 and go to RESP.
- RESP: ack=1 for exactly this cycle, mem_en=0. Next state is IDLE.
- Latency: from the edge that samples req to ack visible is WAIT_CYC+2 cycles. Throughput is one access per WAIT_CYC+3 cycles.
- Stores: mem_wdata=dm_wdata and mem_be=dm_be. dm_rdata is unchanged.
- Fetch: mem_be=4'hF.
- Requester rule: drop req in the cycle after ack, or keep it high with new operands to issue a back-to-back request. A held req is re-arbitrated in IDLE.
- Simultaneous requests: data is served first. Fetch is served in the next IDLE unless a new dm_req is pending at that edge.
- Inputs that change during ACCESS are ignored, because operands are latched at grant.
- Reset asserted mid-ACCESS: the transaction is abandoned, no ack is issued, and mem_en drops immediately.
- busy = (state != IDLE).
- owner holds its last value in IDLE.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A streak counter increments on each data grant made while if_req is high.
  - It clears on any fetch grant, and on any data grant made while if_req is low.
  - When streak == STREAK_MAX and if_req is high, the next grant goes to fetch even if dm_req is high.
- Undefined: strict data priority, no streak counter; fetch can starve indefinitely.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with no reqs → busy=0, mem_en=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
- Single fetch, WAIT_CYC=1:
  - Stimulus: if_req=1, if_addr=0x00400000, mem_rdata=0x1880FFFE.
  - Required: mem_en high for 2 cycles with mem_addr=0x00400000 and mem_be=F.
  - Required: if_ack pulses 3 cycles after the grant edge, and if_rdata=0x1880FFFE.
- Store then load:
  - Stimulus: dm_we=1, addr 0x10010000, wdata 0x000000AA, be 4'b0001; then dm_we=0 at the same address, with the memory model returning 0x000000AA.
  - Required: mem_we=1 only during the store's ACCESS state, and dm_rdata=0x000000AA after the second dm_ack.
- Contention:
  - Stimulus: if_req and dm_req rise on the same edge.
  - Required: owner=1 first, dm_ack precedes if_ack, if_ack arrives WAIT_CYC+3 cycles after dm_ack, and no overlapping acks.
- Fairness (MEM_ARB_FAIR_EN, STREAK_MAX=4):
  - Stimulus: dm_req held high continuously with if_req high.
  - Required: exactly 4 dm_acks, then one if_ack, then data resumes.
  - Without the macro, no if_ack occurs over 20 accesses.
- Reset mid-access:
  - Stimulus: assert reset=0 in the 2nd ACCESS cycle of a load.
  - Required: mem_en=0 immediately, dm_ack never pulses, dm_rdata=0, state returns to IDLE after release.
